// File: rtl/carry_skip_pkg.sv
// Shared helpers for the pipelined carry-skip adder-subtractor:
// block counting and parameter legality checks used at elaboration.
package carry_skip_pkg;

    // Number of R-bit ripple blocks inside one W-bit carry-skip segment.
    function automatic int num_blocks(input int width, input int r);
        return width / r;
    endfunction

    // Legal geometry: S >= 1, M divisible by S, M/S divisible by R, M/S > R.
    function automatic bit params_ok(input int m, input int s, input int r);
        if (s < 1 || r < 1)
            return 1'b0;
        if (m % s != 0)
            return 1'b0;
        if ((m / s) % r != 0)
            return 1'b0;
        return (m / s) > r;
    endfunction

endpackage

// File: rtl/carry_skip_segment.sv
// Combinational W-bit carry-skip adder segment built from R-bit ripple blocks.
// First and last blocks ripple only; middle blocks add a skip path.
module carry_skip_segment
    import carry_skip_pkg::*;
#(
    parameter int W = 16,
    parameter int R = 4
) (
    input  logic         cin,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] out,
    output logic         cout,
    output logic         c_msb
);

    localparam int NB = num_blocks(W, R);

    if ((W % R != 0) || (W <= R)) begin : g_param_err
        $error("carry_skip_segment: W must be a multiple of R and larger than R");
    end

    // Ripple through each block; middle blocks may bypass via all-propagate.
    always_comb begin
        logic w_c;
        logic w_c_blk;
        logic w_all_p;
        logic w_p;
        w_c     = cin;
        w_c_blk = 1'b0;
        w_all_p = 1'b0;
        w_p     = 1'b0;
        out     = '0;
        c_msb   = 1'b0;
        for (int b = 0; b < NB; b++) begin
            w_c_blk = w_c;
            w_all_p = 1'b1;
            for (int j = 0; j < R; j++) begin
                w_p = x[b*R+j] ^ y[b*R+j];
                if (b*R + j == W - 1)
                    c_msb = w_c;
                out[b*R+j] = w_p ^ w_c;
                w_c        = (x[b*R+j] & y[b*R+j]) | (w_p & w_c);
                w_all_p    = w_all_p & w_p;
            end
            if (b != 0 && b != NB - 1)
                w_c = (w_c_blk & w_all_p) | w_c;
        end
        cout = w_c;
    end

endmodule

// File: rtl/pipelined_carry_skip_add_sub.sv
// S-stage pipelined carry-skip adder-subtractor with valid/ready flow control.
// Stage k adds slice k; skew registers carry upper operands and lower results.
module pipelined_carry_skip_add_sub
    import carry_skip_pkg::*;
#(
    parameter int M = 32,
    parameter int R = 4,
    parameter int S = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sub,
    input  logic         cin,
    input  logic [M-1:0] x,
    input  logic [M-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out,
    output logic         cout,
    output logic         v,
    output logic         zero
);

    localparam int W = M / S;

    if (!params_ok(M, S, R)) begin : g_param_err
        $error("pipelined_carry_skip_add_sub: illegal M/S/R combination");
    end

    logic [S-1:0] r_valid;
    logic [M-1:0] r_x   [S];
    logic [M-1:0] r_y   [S];
    logic [M-1:0] r_res [S];
    logic         r_c   [S];
    logic         r_v;
    logic         r_zero;

    logic [S:0]   w_ready;
    logic [S-1:0] w_vin;
    logic [M-1:0] w_src_x   [S];
    logic [M-1:0] w_src_y   [S];
    logic [M-1:0] w_src_res [S];
    logic         w_src_c   [S];
    logic [M-1:0] w_nxt_res [S];
    logic [W-1:0] w_seg_out [S];
    logic         w_seg_cout[S];
    logic         w_seg_cmsb[S];

    // Ready chain from the output back to the input; no bubble on full drain.
    always_comb begin
        w_ready    = '0;
        w_ready[S] = out_ready;
        for (int k = S - 1; k >= 0; k--)
            w_ready[k] = !r_valid[k] | w_ready[k+1];
    end

    assign in_ready = w_ready[0];

    // Stage inputs: stage 0 takes the operands (y inverted for subtract),
    // later stages take the previous stage's skew registers and carry.
    always_comb begin
        w_vin[0]     = in_valid;
        w_src_x[0]   = x;
        w_src_y[0]   = y ^ {M{sub}};
        w_src_res[0] = '0;
        w_src_c[0]   = sub | cin;
        for (int k = 1; k < S; k++) begin
            w_vin[k]     = r_valid[k-1];
            w_src_x[k]   = r_x[k-1];
            w_src_y[k]   = r_y[k-1];
            w_src_res[k] = r_res[k-1];
            w_src_c[k]   = r_c[k-1];
        end
    end

    for (genvar gi = 0; gi < S; gi++) begin : g_stage
        carry_skip_segment #(
            .W(W),
            .R(R)
        ) u_seg (
            .cin  (w_src_c[gi]),
            .x    (w_src_x[gi][gi*W +: W]),
            .y    (w_src_y[gi][gi*W +: W]),
            .out  (w_seg_out[gi]),
            .cout (w_seg_cout[gi]),
            .c_msb(w_seg_cmsb[gi])
        );
    end

    // Merge each stage's freshly computed slice into its partial result.
    always_comb begin
        for (int k = 0; k < S; k++) begin
            w_nxt_res[k]          = w_src_res[k];
            w_nxt_res[k][k*W +: W] = w_seg_out[k];
        end
    end

    // Pipeline and skew registers; each stage advances when its ready is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_v     <= 1'b0;
            r_zero  <= 1'b0;
            for (int k = 0; k < S; k++) begin
                r_x[k]   <= '0;
                r_y[k]   <= '0;
                r_res[k] <= '0;
                r_c[k]   <= 1'b0;
            end
        end else begin
            for (int k = 0; k < S; k++) begin
                if (w_ready[k]) begin
                    r_valid[k] <= w_vin[k];
                    r_x[k]     <= w_src_x[k];
                    r_y[k]     <= w_src_y[k];
                    r_res[k]   <= w_nxt_res[k];
                    r_c[k]     <= w_seg_cout[k];
                end
            end
            if (w_ready[S-1]) begin
                r_v    <= w_seg_cmsb[S-1] ^ w_seg_cout[S-1];
                r_zero <= ~|w_nxt_res[S-1];
            end
        end
    end

    assign out_valid = r_valid[S-1];
    assign out       = r_res[S-1];
    assign cout      = r_c[S-1];
    assign v         = r_v;
    assign zero      = r_zero;

endmodule
